// File: rtl/hart_pkg.sv
// ---------------------------------------------------------------------------
// hart_pkg
// Shared definitions for the heartbeat rate meter: parameter defaults, the
// measurement FSM state encoding and the saturation limit of the rate word.
// No ports (package).
// ---------------------------------------------------------------------------
package hart_pkg;

    // Default numerator: 64 Hz tick * 60 s / 2, so one rate unit is 2 bpm.
    localparam int RATE_K_DEF  = 1920;
    localparam int NUM_W_DEF   = 12;
    localparam int CNT_W_DEF   = 12;
    // Refractory window; must exceed NUM_W+1 so no beat is accepted mid-divide.
    localparam int MIN_IVL_DEF = 16;

    // Largest value representable by the 6-bit rate output.
    localparam int HART_MAX    = 63;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE,
        TIMEOUT
    } state_t;

endpackage

// File: rtl/hart_divider.sv
// ---------------------------------------------------------------------------
// hart_divider
// Sequential restoring divider computing RATE_K / divisor, one quotient bit
// per clock for NUM_W clocks.
// Ports:
//   slow     in   clock, rising edge
//   reset    in   synchronous active-high reset, aborts a divide in progress
//   start    in   load divisor and begin a new divide
//   divisor  in   DIV_W-bit divisor (must be non-zero)
//   busy     out  a divide is in progress or its result is being presented
//   done     out  quotient valid this cycle (single cycle)
//   quotient out  NUM_W-bit quotient
// ---------------------------------------------------------------------------
module hart_divider
    import hart_pkg::*;
#(
    parameter int RATE_K = RATE_K_DEF,
    parameter int NUM_W  = NUM_W_DEF,
    parameter int DIV_W  = CNT_W_DEF
) (
    input  logic             slow,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int CW = $clog2(NUM_W + 1);

    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] dvs;
    logic [NUM_W-1:0] quo;
    logic [CW-1:0]    count;

    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   diff;
    logic             ge;

    // The partial remainder is always below the divisor, so shifting in the
    // next numerator bit needs just one extra bit of headroom.
    always_comb begin
        trial = {rem, quo[NUM_W-1]};
        ge    = trial >= {1'b0, dvs};
        diff  = trial - {1'b0, dvs};
    end

    // quo starts out holding the numerator; each step shifts out its top bit
    // into the remainder and shifts in the new quotient bit at the bottom.
    always_ff @(posedge slow) begin
        if (reset) begin
            rem   <= '0;
            dvs   <= '0;
            quo   <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            dvs   <= divisor;
            quo   <= NUM_W'(RATE_K);
            count <= CW'(NUM_W);
            busy  <= 1'b1;
        end else if (busy) begin
            if (count != '0) begin
                rem   <= ge ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
                quo   <= {quo[NUM_W-2:0], ge};
                count <= count - 1'b1;
            end else begin
                busy  <= 1'b0;
            end
        end
    end

    assign done     = busy && (count == '0);
    assign quotient = quo;

endmodule

// File: rtl/hart_rate_meter.sv
// ---------------------------------------------------------------------------
// hart_rate_meter
// Turns the raw heartbeat sensor pulse into a 6-bit rate word (2 bpm units).
// The beat is synchronised and edge-detected, the interval between accepted
// beats is counted in ticks, and RATE_K / interval is computed by a
// sequential divider and saturated to 6 bits. A long silence forces 0.
// Ports:
//   slow       in   system tick clock, rising edge
//   reset      in   synchronous active-high reset
//   beat       in   raw sensor pulse, asynchronous, active-high
//   hart       out  current rate, 2 bpm per unit
//   hart_valid out  one-cycle pulse whenever hart is updated
//   timeout    out  high while there is no valid beat history
// ---------------------------------------------------------------------------
module hart_rate_meter
    import hart_pkg::*;
#(
    parameter int RATE_K  = RATE_K_DEF,
    parameter int NUM_W   = NUM_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MIN_IVL = MIN_IVL_DEF
) (
    input  logic       slow,
    input  logic       reset,
    input  logic       beat,
    output logic [5:0] hart,
    output logic       hart_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] IVL_MAX = '1;
    localparam logic [CNT_W-1:0] IVL_PRE = IVL_MAX - CNT_W'(1);

    state_t state;
    state_t next_state;

    logic beat_meta;
    logic beat_sync;
    logic beat_prev;
    logic rise;
    logic accept;

    logic [CNT_W-1:0] ivl;

    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] quotient;
    logic [5:0]       hart_sat;

    logic load_result;
    logic load_timeout;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge slow) begin
        if (reset) begin
            beat_meta <= 1'b0;
            beat_sync <= 1'b0;
            beat_prev <= 1'b0;
        end else begin
            beat_meta <= beat;
            beat_sync <= beat_meta;
            beat_prev <= beat_sync;
        end
    end

    assign rise = beat_sync & ~beat_prev;

    // A rise only counts when we are waiting for a first beat or when the
    // refractory window since the previous accepted beat has elapsed.
    assign accept = rise &&
                    ((state == IDLE) ||
                     ((state == MEASURE) && (ivl >= CNT_W'(MIN_IVL))));

    // Interval counter restarts at 1 so that a spacing of d ticks reads d at
    // the next accepted rise; it saturates to flag the silence condition.
    always_ff @(posedge slow) begin
        if (reset) begin
            ivl <= '0;
        end else if (accept) begin
            ivl <= CNT_W'(1);
        end else if (ivl != IVL_MAX) begin
            ivl <= ivl + CNT_W'(1);
        end
    end

    always_ff @(posedge slow) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. The timeout branch fires as the counter
    // steps onto its saturation value so the zero output appears one cycle
    // after saturation. In DIVIDE, losing busy without done can only follow
    // an abnormal divider state, so we fall back to measuring.
    always_comb begin
        next_state   = state;
        div_start    = 1'b0;
        load_result  = 1'b0;
        load_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = MEASURE;
                end
            end
            MEASURE: begin
                if (accept) begin
                    div_start  = 1'b1;
                    next_state = DIVIDE;
                end else if (ivl == IVL_PRE) begin
                    next_state = TIMEOUT;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    load_result = 1'b1;
                    next_state  = MEASURE;
                end else if (!div_busy) begin
                    next_state  = MEASURE;
                end
            end
            TIMEOUT: begin
                load_timeout = 1'b1;
                next_state   = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    hart_divider #(
        .RATE_K (RATE_K),
        .NUM_W  (NUM_W),
        .DIV_W  (CNT_W)
    ) u_divider (
        .slow     (slow),
        .reset    (reset),
        .start    (div_start),
        .divisor  (ivl),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    assign hart_sat = (quotient > NUM_W'(HART_MAX)) ? 6'(HART_MAX) : quotient[5:0];

    // Output registers: hart holds between updates, hart_valid pulses once
    // per update, timeout clears on a real measurement and sets on silence.
    always_ff @(posedge slow) begin
        if (reset) begin
            hart       <= '0;
            hart_valid <= 1'b0;
            timeout    <= 1'b1;
        end else begin
            hart_valid <= 1'b0;
            if (load_result) begin
                hart       <= hart_sat;
                hart_valid <= 1'b1;
                timeout    <= 1'b0;
            end else if (load_timeout) begin
                hart       <= '0;
                hart_valid <= 1'b1;
                timeout    <= 1'b1;
            end
        end
    end

endmodule
